// File: rtl/tap_ctrl.sv
// ---------------------------------------------------------------------------
// tap_ctrl
//   1149.1-style TAP controller for the dr block. It contains a 16-state
//   TMS-driven FSM, an IR_W-bit instruction register with a capture/shift
//   shifter and instruction decode, a 1-bit bypass register and the TDO
//   output multiplexer.
//
// Ports
//   TCK             test clock. State changes on posedge; TDO/TDO_EN on negedge.
//   TRST_N          asynchronous active-low reset.
//   TMS             mode select, sampled on posedge TCK.
//   TDI             serial data in (IR shifter and bypass).
//   ID_REG_TDO      serial out of the dr IDCODE path (already negedge-registered).
//   BSR_TDO         serial out of the dr BSR path (already negedge-registered).
//   TDO             serial data out.
//   TDO_EN          high while ShIR or ShDR is active (negedge-registered).
//   CAPTUREDR       decode of state == CapDR.
//   SHIFTDR         decode of state == ShDR.
//   UPDATEDR        decode of state == UpdDR.
//   *_SELECT        one-hot instruction decode of the IR.
//   TAP_STATE       current state code (debug).
// ---------------------------------------------------------------------------
module tap_ctrl #(
  parameter int              IR_W       = 4,
  parameter logic [IR_W-1:0] IR_RESET   = IR_W'(4'h1),
  parameter logic [IR_W-1:0] IR_CAPTURE = IR_W'(4'b0101)
) (
  input  logic       TCK,
  input  logic       TRST_N,
  input  logic       TMS,
  input  logic       TDI,
  input  logic       ID_REG_TDO,
  input  logic       BSR_TDO,
  output logic       TDO,
  output logic       TDO_EN,
  output logic       CAPTUREDR,
  output logic       SHIFTDR,
  output logic       UPDATEDR,
  output logic       IDCODE_SELECT,
  output logic       SAMPLE_SELECT,
  output logic       EXTEST_SELECT,
  output logic       INTEST_SELECT,
  output logic       USERCODE_SELECT,
  output logic       RUNBIST_SELECT,
  output logic       BYPASS_SELECT,
  output logic [3:0] TAP_STATE
);

  typedef enum logic [3:0] {
    S_TLR   = 4'hF,
    S_RTI   = 4'hC,
    S_SELDR = 4'h7,
    S_CAPDR = 4'h6,
    S_SHDR  = 4'h2,
    S_EX1DR = 4'h1,
    S_PSDR  = 4'h3,
    S_EX2DR = 4'h0,
    S_UPDDR = 4'h5,
    S_SELIR = 4'h4,
    S_CAPIR = 4'hE,
    S_SHIR  = 4'hA,
    S_EX1IR = 4'h9,
    S_PSIR  = 4'hB,
    S_EX2IR = 4'h8,
    S_UPDIR = 4'hD
  } tap_state_e;

  // Which source drives TDO during the current low phase of TCK.
  typedef enum logic [1:0] {
    SRC_REG = 2'd0,  // internally registered bit (IR shifter, bypass or 0)
    SRC_ID  = 2'd1,  // dr IDCODE chain
    SRC_BSR = 2'd2   // dr BSR chain
  } tdo_src_e;

  localparam logic [IR_W-1:0] OP_EXTEST   = IR_W'(4'h0);
  localparam logic [IR_W-1:0] OP_IDCODE   = IR_W'(4'h1);
  localparam logic [IR_W-1:0] OP_SAMPLE   = IR_W'(4'h2);
  localparam logic [IR_W-1:0] OP_INTEST   = IR_W'(4'h3);
  localparam logic [IR_W-1:0] OP_USERCODE = IR_W'(4'h4);
  localparam logic [IR_W-1:0] OP_RUNBIST  = IR_W'(4'h5);

  tap_state_e      r_state;
  tap_state_e      w_next;
  logic [IR_W-1:0] r_ir;
  logic [IR_W-1:0] r_ir_sh;
  logic            r_bypass;
  logic            r_tdo_reg;
  tdo_src_e        r_tdo_src;
  logic            r_tdo_en;

  logic            w_sel_idcode;
  logic            w_sel_sample;
  logic            w_sel_extest;
  logic            w_sel_intest;
  logic            w_sel_usercode;
  logic            w_sel_runbist;
  logic            w_sel_bypass;
  logic            w_shift_state;
  logic            w_tdo_reg_nxt;
  tdo_src_e        w_tdo_src_nxt;

  // -------------------------------------------------------------------------
  // TAP FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) r_state <= S_TLR;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = S_TLR;
    case (r_state)
      S_TLR:   w_next = TMS ? S_TLR   : S_RTI;
      S_RTI:   w_next = TMS ? S_SELDR : S_RTI;
      S_SELDR: w_next = TMS ? S_SELIR : S_CAPDR;
      S_CAPDR: w_next = TMS ? S_EX1DR : S_SHDR;
      S_SHDR:  w_next = TMS ? S_EX1DR : S_SHDR;
      S_EX1DR: w_next = TMS ? S_UPDDR : S_PSDR;
      S_PSDR:  w_next = TMS ? S_EX2DR : S_PSDR;
      S_EX2DR: w_next = TMS ? S_UPDDR : S_SHDR;
      S_UPDDR: w_next = TMS ? S_SELDR : S_RTI;
      S_SELIR: w_next = TMS ? S_TLR   : S_CAPIR;
      S_CAPIR: w_next = TMS ? S_EX1IR : S_SHIR;
      S_SHIR:  w_next = TMS ? S_EX1IR : S_SHIR;
      S_EX1IR: w_next = TMS ? S_UPDIR : S_PSIR;
      S_PSIR:  w_next = TMS ? S_EX2IR : S_PSIR;
      S_EX2IR: w_next = TMS ? S_UPDIR : S_SHIR;
      S_UPDIR: w_next = TMS ? S_SELDR : S_RTI;
      default: w_next = S_TLR;
    endcase
  end

  // Registered-state decodes only: dr acts on the posedge that leaves the
  // state, and there is no combinational path from TMS.
  assign TAP_STATE     = r_state;
  assign CAPTUREDR     = (r_state == S_CAPDR);
  assign SHIFTDR       = (r_state == S_SHDR);
  assign UPDATEDR      = (r_state == S_UPDDR);
  assign w_shift_state = (r_state == S_SHDR) || (r_state == S_SHIR);

  // -------------------------------------------------------------------------
  // Instruction register and its shifter
  // -------------------------------------------------------------------------
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      r_ir_sh <= '0;
      r_ir    <= IR_RESET;
    end else begin
      case (r_state)
        S_CAPIR: r_ir_sh <= IR_CAPTURE;
        S_SHIR:  r_ir_sh <= {TDI, r_ir_sh[IR_W-1:1]};
        default: r_ir_sh <= r_ir_sh;
      endcase
      // Reload on every posedge that lands in TLR, so holding TMS high
      // always restores IDCODE regardless of the path taken.
      if (w_next == S_TLR)
        r_ir <= IR_RESET;
      else if (r_state == S_UPDIR)
        r_ir <= r_ir_sh;
    end
  end

  // Unlisted opcodes fall into BYPASS so exactly one select is always high.
  always_comb begin
    w_sel_idcode   = 1'b0;
    w_sel_sample   = 1'b0;
    w_sel_extest   = 1'b0;
    w_sel_intest   = 1'b0;
    w_sel_usercode = 1'b0;
    w_sel_runbist  = 1'b0;
    w_sel_bypass   = 1'b0;
    case (r_ir)
      OP_EXTEST:   w_sel_extest   = 1'b1;
      OP_IDCODE:   w_sel_idcode   = 1'b1;
      OP_SAMPLE:   w_sel_sample   = 1'b1;
      OP_INTEST:   w_sel_intest   = 1'b1;
      OP_USERCODE: w_sel_usercode = 1'b1;
      OP_RUNBIST:  w_sel_runbist  = 1'b1;
      default:     w_sel_bypass   = 1'b1;
    endcase
  end

  assign IDCODE_SELECT   = w_sel_idcode;
  assign SAMPLE_SELECT   = w_sel_sample;
  assign EXTEST_SELECT   = w_sel_extest;
  assign INTEST_SELECT   = w_sel_intest;
  assign USERCODE_SELECT = w_sel_usercode;
  assign RUNBIST_SELECT  = w_sel_runbist;
  assign BYPASS_SELECT   = w_sel_bypass;

  // -------------------------------------------------------------------------
  // Bypass register
  // -------------------------------------------------------------------------
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N)
      r_bypass <= 1'b0;
    else if (w_sel_bypass && (r_state == S_CAPDR))
      r_bypass <= 1'b0;
    else if (w_sel_bypass && (r_state == S_SHDR))
      r_bypass <= TDI;
  end

  // -------------------------------------------------------------------------
  // TDO path. Internal bits are retimed on negedge. The dr chains are
  // already negedge-registered, so only their mux select is retimed here and
  // the data passes straight through; all sources then change together.
  // -------------------------------------------------------------------------
  always_comb begin
    w_tdo_reg_nxt = 1'b0;
    w_tdo_src_nxt = SRC_REG;
    if (r_state == S_SHIR) begin
      w_tdo_reg_nxt = r_ir_sh[0];
    end else if (r_state == S_SHDR) begin
      if (w_sel_bypass)      w_tdo_reg_nxt = r_bypass;
      else if (w_sel_idcode) w_tdo_src_nxt = SRC_ID;
      else                   w_tdo_src_nxt = SRC_BSR;
    end
  end

  always_ff @(negedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      r_tdo_reg <= 1'b0;
      r_tdo_src <= SRC_REG;
      r_tdo_en  <= 1'b0;
    end else begin
      r_tdo_reg <= w_tdo_reg_nxt;
      r_tdo_src <= w_tdo_src_nxt;
      r_tdo_en  <= w_shift_state;
    end
  end

  always_comb begin
    TDO = r_tdo_reg;
    case (r_tdo_src)
      SRC_ID:  TDO = ID_REG_TDO;
      SRC_BSR: TDO = BSR_TDO;
      default: TDO = r_tdo_reg;
    endcase
  end

  assign TDO_EN = r_tdo_en;

endmodule

// File: tb/tb_tap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tap_ctrl
//   Directed bench for tap_ctrl: a table of {TMS, TDI -> expected outputs}
//   records walks the FSM and performs an IR capture/load, followed by short
//   hand-written sequences for reset, TLR entry, bypass, the DR mux and the
//   full opcode decode.
// ---------------------------------------------------------------------------
module tb_tap_ctrl;

  logic       TCK = 1'b0;
  logic       TRST_N;
  logic       TMS;
  logic       TDI;
  logic       ID_REG_TDO;
  logic       BSR_TDO;
  logic       TDO;
  logic       TDO_EN;
  logic       CAPTUREDR, SHIFTDR, UPDATEDR;
  logic       IDCODE_SELECT, SAMPLE_SELECT, EXTEST_SELECT, INTEST_SELECT;
  logic       USERCODE_SELECT, RUNBIST_SELECT, BYPASS_SELECT;
  logic [3:0] TAP_STATE;

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Selects packed as {IDCODE,SAMPLE,EXTEST,INTEST,USERCODE,RUNBIST,BYPASS}.
  localparam logic [6:0] SEL_ID  = 7'b1000000;
  localparam logic [6:0] SEL_SMP = 7'b0100000;
  localparam logic [6:0] SEL_EXT = 7'b0010000;
  localparam logic [6:0] SEL_INT = 7'b0001000;
  localparam logic [6:0] SEL_USR = 7'b0000100;
  localparam logic [6:0] SEL_RBT = 7'b0000010;
  localparam logic [6:0] SEL_BYP = 7'b0000001;

  logic [6:0] sel;
  logic [2:0] cud;
  assign sel = {IDCODE_SELECT, SAMPLE_SELECT, EXTEST_SELECT, INTEST_SELECT,
                USERCODE_SELECT, RUNBIST_SELECT, BYPASS_SELECT};
  assign cud = {CAPTUREDR, SHIFTDR, UPDATEDR};

  tap_ctrl dut (
    .TCK             (TCK),
    .TRST_N          (TRST_N),
    .TMS             (TMS),
    .TDI             (TDI),
    .ID_REG_TDO      (ID_REG_TDO),
    .BSR_TDO         (BSR_TDO),
    .TDO             (TDO),
    .TDO_EN          (TDO_EN),
    .CAPTUREDR       (CAPTUREDR),
    .SHIFTDR         (SHIFTDR),
    .UPDATEDR        (UPDATEDR),
    .IDCODE_SELECT   (IDCODE_SELECT),
    .SAMPLE_SELECT   (SAMPLE_SELECT),
    .EXTEST_SELECT   (EXTEST_SELECT),
    .INTEST_SELECT   (INTEST_SELECT),
    .USERCODE_SELECT (USERCODE_SELECT),
    .RUNBIST_SELECT  (RUNBIST_SELECT),
    .BYPASS_SELECT   (BYPASS_SELECT),
    .TAP_STATE       (TAP_STATE)
  );

  always #5 TCK = ~TCK;

  typedef struct {
    logic       tms;
    logic       tdi;
    logic [3:0] st;
    logic       tdo;
    logic       en;
    logic [2:0] cud;   // {CAPTUREDR, SHIFTDR, UPDATEDR}
    logic [6:0] sel;
  } vec_t;

  vec_t tbl [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply TMS/TDI, take one posedge, then sample just after the following
  // negedge so registered TDO/TDO_EN are settled. One-hot is checked each time.
  task automatic tick(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    @(negedge TCK);
    #1;
    check("sel_onehot", 32'($onehot(sel)), 32'd1);
  endtask

  // From RTI: load code into the IR and return to RTI. First TDI bit ends at IR[0].
  task automatic load_ir(input logic [3:0] code);
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);   // SelDR, SelIR, CapIR, ShIR
    for (int i = 0; i < 4; i++) tick(i == 3, code[i]);
    tick(1, 0);                                        // UpdIR
    tick(0, 0);                                        // RTI, IR updated
    check("load_ir_state", TAP_STATE, 4'hC);
  endtask

  // From RTI into ShDR (capture posedge taken).
  task automatic goto_shdr();
    tick(1, 0); tick(0, 0); tick(0, 1);
    check("goto_shdr_state", TAP_STATE, 4'h2);
  endtask

  function automatic logic [6:0] exp_sel(input logic [3:0] op);
    case (op)
      4'h0:    return SEL_EXT;
      4'h1:    return SEL_ID;
      4'h2:    return SEL_SMP;
      4'h3:    return SEL_INT;
      4'h4:    return SEL_USR;
      4'h5:    return SEL_RBT;
      default: return SEL_BYP;
    endcase
  endfunction

  initial begin
    // tms tdi  state  tdo en  cud     sel
    tbl[0]  = '{0, 0, 4'hC, 0, 0, 3'b000, SEL_ID};
    tbl[1]  = '{1, 0, 4'h7, 0, 0, 3'b000, SEL_ID};
    tbl[2]  = '{0, 0, 4'h6, 0, 0, 3'b100, SEL_ID};
    tbl[3]  = '{0, 0, 4'h2, 0, 1, 3'b010, SEL_ID};
    tbl[4]  = '{1, 0, 4'h1, 0, 0, 3'b000, SEL_ID};
    tbl[5]  = '{0, 0, 4'h3, 0, 0, 3'b000, SEL_ID};
    tbl[6]  = '{1, 0, 4'h0, 0, 0, 3'b000, SEL_ID};
    tbl[7]  = '{1, 0, 4'h5, 0, 0, 3'b001, SEL_ID};
    tbl[8]  = '{0, 0, 4'hC, 0, 0, 3'b000, SEL_ID};
    // IR capture then shift in 0000: TDO shows IR_CAPTURE LSB first 1,0,1,0
    tbl[9]  = '{1, 0, 4'h7, 0, 0, 3'b000, SEL_ID};
    tbl[10] = '{1, 0, 4'h4, 0, 0, 3'b000, SEL_ID};
    tbl[11] = '{0, 0, 4'hE, 0, 0, 3'b000, SEL_ID};
    tbl[12] = '{0, 0, 4'hA, 1, 1, 3'b000, SEL_ID};
    tbl[13] = '{0, 0, 4'hA, 0, 1, 3'b000, SEL_ID};
    tbl[14] = '{0, 0, 4'hA, 1, 1, 3'b000, SEL_ID};
    tbl[15] = '{0, 0, 4'hA, 0, 1, 3'b000, SEL_ID};
    tbl[16] = '{1, 0, 4'h9, 0, 0, 3'b000, SEL_ID};
    tbl[17] = '{1, 0, 4'hD, 0, 0, 3'b000, SEL_ID};
    tbl[18] = '{0, 0, 4'hC, 0, 0, 3'b000, SEL_EXT};

    TRST_N = 1'b0; TMS = 1'b1; TDI = 1'b0; ID_REG_TDO = 1'b0; BSR_TDO = 1'b0;
    #23;
    check("rst_state",  TAP_STATE, 4'hF);
    check("rst_sel",    sel, SEL_ID);
    check("rst_cud",    cud, 3'b000);
    check("rst_tdo_en", TDO_EN, 1'b0);
    check("rst_tdo",    TDO, 1'b0);
    @(negedge TCK); #1;
    TRST_N = 1'b1;

    // Table-driven FSM walk and IR load
    for (int i = 0; i < 19; i++) begin
      tick(tbl[i].tms, tbl[i].tdi);
      check($sformatf("tbl%0d_state", i),  TAP_STATE, tbl[i].st);
      check($sformatf("tbl%0d_tdo", i),    TDO,       tbl[i].tdo);
      check($sformatf("tbl%0d_tdo_en", i), TDO_EN,    tbl[i].en);
      check($sformatf("tbl%0d_cud", i),    cud,       tbl[i].cud);
      check($sformatf("tbl%0d_sel", i),    sel,       tbl[i].sel);
    end

    // Asynchronous reset in the middle of ShDR (IR currently EXTEST)
    goto_shdr();
    check("pre_rst_tdo_en", TDO_EN, 1'b1);
    #2 TRST_N = 1'b0;
    #1;
    check("arst_state",  TAP_STATE, 4'hF);
    check("arst_sel",    sel, SEL_ID);
    check("arst_tdo_en", TDO_EN, 1'b0);
    check("arst_cud",    cud, 3'b000);
    @(negedge TCK); #1;
    TRST_N = 1'b1;

    // Five TMS=1 posedges from RTI reach TLR
    tick(0, 0);
    check("rti_state", TAP_STATE, 4'hC);
    for (int i = 0; i < 5; i++) tick(1, 0);
    check("tms5_from_rti", TAP_STATE, 4'hF);
    tick(0, 0);

    // Unknown opcode 9 selects bypass; bypass delays TDI by one bit
    load_ir(4'h9);
    check("op9_sel", sel, SEL_BYP);
    goto_shdr();
    check("byp_cap_tdo", TDO, 1'b0);
    tick(0, 1); check("byp_sh1_tdo", TDO, 1'b1);
    tick(0, 1); check("byp_sh2_tdo", TDO, 1'b1);
    tick(0, 0); check("byp_sh3_tdo", TDO, 1'b0);
    tick(1, 1); check("byp_ex1_tdo", TDO, 1'b0);   // bypass now holds 1
    tick(1, 0); tick(0, 0);
    goto_shdr();                                    // capture must clear it
    check("byp_recap_tdo", TDO, 1'b0);
    tick(1, 0); tick(1, 0); tick(0, 0);

    // DR mux: IDCODE follows ID_REG_TDO
    load_ir(4'h1);
    check("idcode_sel", sel, SEL_ID);
    goto_shdr();
    ID_REG_TDO = 1'b1; BSR_TDO = 1'b0; #1;
    check("id_tdo_hi", TDO, 1'b1);
    ID_REG_TDO = 1'b0; BSR_TDO = 1'b1; #1;
    check("id_tdo_lo", TDO, 1'b0);
    tick(1, 0); tick(1, 0); tick(0, 0);

    // SAMPLE follows BSR_TDO; leaving ShDR forces TDO/TDO_EN low
    load_ir(4'h2);
    check("sample_sel", sel, SEL_SMP);
    goto_shdr();
    ID_REG_TDO = 1'b1; BSR_TDO = 1'b0; #1;
    check("bsr_tdo_lo", TDO, 1'b0);
    ID_REG_TDO = 1'b0; BSR_TDO = 1'b1; #1;
    check("bsr_tdo_hi", TDO, 1'b1);
    check("bsr_tdo_en", TDO_EN, 1'b1);
    tick(1, 0);
    check("ex1_state",  TAP_STATE, 4'h1);
    check("ex1_tdo",    TDO, 1'b0);
    check("ex1_tdo_en", TDO_EN, 1'b0);
    BSR_TDO = 1'b0;

    // Entering TLR reloads IDCODE; the select holds until that posedge
    tick(1, 0); tick(1, 0); tick(1, 0);
    check("pre_tlr_state", TAP_STATE, 4'h4);
    check("pre_tlr_sel",   sel, SEL_SMP);
    tick(1, 0);
    check("tlr_state", TAP_STATE, 4'hF);
    check("tlr_sel",   sel, SEL_ID);
    tick(0, 0);

    // Every opcode decodes to its select (one-hot checked on every tick)
    for (int op = 0; op < 16; op++) begin
      load_ir(4'(op));
      check($sformatf("op%0h_sel", op), sel, exp_sel(4'(op)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tap_ctrl.md
Name: tap_ctrl

Overview:
- IEEE 1149.1-style TAP controller feeding the dr block: 16-state TMS-driven FSM, 4-bit instruction register with decode, 1-bit bypass register and TDO output multiplexer.
- Produces CAPTUREDR/SHIFTDR/UPDATEDR and the one-hot *_SELECT lines consumed by dr.
- Muxes dr's serial outputs, the IR and bypass onto TDO.

Parameters:
- IR_W, 4, instruction register width (opcodes below assume 4).
- IR_RESET, 4'h1, instruction loaded on reset (IDCODE).
- IR_CAPTURE, 4'b0101, value captured into the IR shifter in Capture-IR (LSBs 01).

Ports:
- TCK  in  1  test clock; all state changes on posedge, TDO on negedge.
- TRST_N  in  1  asynchronous active-low reset.
- TMS  in  1  mode select, sampled on posedge TCK.
- TDI  in  1  serial data in (IR and bypass shifters).
- ID_REG_TDO  in  1  serial out of dr IDCODE path (already negedge-registered).
- BSR_TDO  in  1  serial out of dr BSR path (already negedge-registered).
- TDO  out  1  serial data out.
- TDO_EN  out  1  high while a shift state is active.
- CAPTUREDR, SHIFTDR, UPDATEDR  out  1 each  state decodes to dr.
- IDCODE_SELECT, SAMPLE_SELECT, EXTEST_SELECT, INTEST_SELECT, USERCODE_SELECT, RUNBIST_SELECT, BYPASS_SELECT  out  1 each  instruction decode.
- TAP_STATE  out  4  current state code (debug).

Behaviour:
- Reset: TRST_N low forces the following asynchronously: state=TLR, IR=IR_RESET, IR shifter=0, bypass=0, TDO=0, TDO_EN=0. Outputs under reset: IDCODE_SELECT=1, other selects 0, CAPTUREDR/SHIFTDR/UPDATEDR=0, TAP_STATE=4'hF. Reset mid-shift aborts; IR is not updated.
- State codes: TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5, SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D.
- Transitions, listed as TMS=0 / TMS=1:
  - TLR: RTI / TLR.
  - RTI: RTI / SelDR.
  - SelDR: CapDR / SelIR.
  - CapDR: ShDR / Ex1DR.
  - ShDR: ShDR / Ex1DR.
  - Ex1DR: PauseDR / UpdDR.
  - PauseDR: PauseDR / Ex2DR.
  - Ex2DR: ShDR / UpdDR.
  - UpdDR: RTI / SelDR.
  - SelIR: CapIR / TLR.
  - IR branch (CapIR..UpdIR) mirrors the DR branch.
- Any state reaches TLR after 5 posedges with TMS=1.
- Entering TLR synchronously reloads IR=IR_RESET.
- CAPTUREDR/SHIFTDR/UPDATEDR: pure decode of the state register (state==CapDR / ShDR / UpdDR), so dr acts on the same posedge that leaves that state. No combinational path from TMS.
- IR shifter:
  - CapIR: loads IR_CAPTURE.
  - ShIR: shifts {TDI, sh[3:1]}, LSB out first.
  - UpdIR: on posedge, IR <= shifter.
- Decode of IR to selects:
  - 0=EXTEST, 1=IDCODE, 2=SAMPLE, 3=INTEST, 4=USERCODE, 5=RUNBIST, F=BYPASS.
  - Every other code asserts BYPASS_SELECT.
  - Exactly one select high at all times; selects change only on the posedge leaving UpdIR or entering TLR.
- Bypass: CapDR with BYPASS_SELECT loads 0; ShDR with BYPASS_SELECT loads TDI.
- TDO source, registered on negedge TCK:
  - ShIR: IR shifter[0].
  - ShDR + BYPASS: bypass bit.
  - All other states: 0.
  - ShDR + IDCODE: ID_REG_TDO passed combinationally, since it is already negedge-registered.
  - ShDR + any other DR instruction: BSR_TDO passed the same way.
- TDO_EN: registered on negedge, equals (state==ShIR || state==ShDR).
- Capture-to-first-bit latency: first TDO bit valid at the negedge after the CapXR→ShXR posedge.

Test Plan:
- Reset/TLR: pulse TRST_N low in ShDR → TAP_STATE=F, IDCODE_SELECT=1, TDO_EN=0. Then from RTI, 5 posedges with TMS=1 → TAP_STATE=F.
- State walk: TMS sequence 0,1,0,0,1,0,1,1,0 from TLR → TAP_STATE steps C,7,6,2,1,3,0,5,C. CAPTUREDR high only in state 6, UPDATEDR only in state 5.
- IR capture/load: enter ShIR, shift in 4'b0000 → TDO shows 1,0,1,0 (IR_CAPTURE LSB first). After UpdIR, EXTEST_SELECT=1 and IDCODE_SELECT=0.
- Unknown opcode: load IR=4'h9 → BYPASS_SELECT=1. In ShDR, TDI pattern 1,1,0 → TDO shows 0,1,1 (captured 0, then 1-bit delay).
- DR mux: with IDCODE, drive ID_REG_TDO=1, BSR_TDO=0 in ShDR → TDO=1. Load SAMPLE → TDO follows BSR_TDO. Exit to Ex1DR → TDO=0 and TDO_EN=0 after the next negedge.
- One-hot check: cycle through all 16 opcodes → exactly one *_SELECT high in every cycle.
